// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching engine host side: state encoding,
// buffer defaults, buffer select and matcher metacharacters.
package sme_pkg;

  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;

  // Plain constants keep the encoding stable for legacy tools and netlists.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_SEND_STR = 3'd1;
  localparam state_t S_SEND_PAT = 3'd2;
  localparam state_t S_WAIT     = 3'd3;
  localparam state_t S_DONE     = 3'd4;

  typedef enum logic {
    SEL_STR = 1'b0,
    SEL_PAT = 1'b1
  } buf_sel_e;

  localparam logic [7:0] META_CARET  = 8'h5E;
  localparam logic [7:0] META_DOLLAR = 8'h24;
  localparam logic [7:0] META_DOT    = 8'h2E;
  localparam logic [7:0] META_STAR   = 8'h2A;

  // Index width for a buffer of the given depth, never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sme_byte_buf.sv
// Byte array with a saturating fill counter and an indexed read port.
// clr together with wr_en restarts the buffer with that byte at index 0.
module sme_byte_buf
  import sme_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int IW = idx_w(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] cnt
);

  logic [7:0] mem [DEPTH];
  logic       full;

  assign full = (cnt == CW'(DEPTH));

  // NOTE: storage has no reset; the counter alone says which bytes are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en && (clr || !full)) begin
      mem[clr ? '0 : cnt[IW-1:0]] <= wr_data;
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= wr_en ? CW'(1) : '0;
    end else if (wr_en && !full) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sme_host_feeder.sv
// Host-side feeder: buffers a string and a pattern, streams them to the matcher
// and returns its result. Define SME_HOST_FEEDER_TIMEOUT_EN to bound the WAIT state.
module sme_host_feeder
  import sme_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF
`ifdef SME_HOST_FEEDER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       reuse_str,
  output logic       busy,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err,
  output logic       res_timeout,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index
);

  localparam int SI_W = idx_w(STR_MAX);
  localparam int PI_W = idx_w(PAT_MAX);
  localparam int SC_W = $clog2(STR_MAX + 1);
  localparam int PC_W = $clog2(PAT_MAX + 1);

  state_t          state, next_state;
  logic [SI_W-1:0] idx, next_idx;
  logic [SC_W-1:0] str_cnt;
  logic [PC_W-1:0] pat_cnt;
  logic [7:0]      str_rd, pat_rd;
  logic            str_fresh;
  logic            wr_accept, str_wr, pat_wr;
  logic            reject, last_str, last_pat, got_result, wait_expired;

  // A start in the same cycle as a write takes priority and the write is lost.
  assign wr_accept  = (state == S_IDLE) && wr_en && !start;
  assign str_wr     = wr_accept && (buf_sel_e'(wr_sel) == SEL_STR);
  assign pat_wr     = wr_accept && (buf_sel_e'(wr_sel) == SEL_PAT);
  assign reject     = (pat_cnt == '0) || ((str_cnt == '0) && !reuse_str);
  assign last_str   = (SC_W'(idx) + SC_W'(1)) == str_cnt;
  assign last_pat   = (PC_W'(idx) + PC_W'(1)) == pat_cnt;
  assign got_result = (state == S_WAIT) && valid;

  sme_byte_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (str_wr && str_fresh),
    .wr_en   (str_wr),
    .wr_data (wr_data),
    .rd_idx  (next_idx),
    .rd_data (str_rd),
    .cnt     (str_cnt)
  );

  sme_byte_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == S_DONE),
    .wr_en   (pat_wr),
    .wr_data (wr_data),
    .rd_idx  (next_idx[PI_W-1:0]),
    .rd_data (pat_rd),
    .cnt     (pat_cnt)
  );

`ifdef SME_HOST_FEEDER_TIMEOUT_EN
  localparam int TW = idx_w(TIMEOUT);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));
`else
  assign wait_expired = 1'b0;
  assign res_timeout  = 1'b0;
`endif

  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_idx = '0;
          if (reject)         next_state = S_DONE;
          else if (reuse_str) next_state = S_SEND_PAT;
          else                next_state = S_SEND_STR;
        end
      end
      S_SEND_STR: begin
        if (last_str) begin
          next_state = S_SEND_PAT;
          next_idx   = '0;
        end else begin
          next_idx = idx + SI_W'(1);
        end
      end
      S_SEND_PAT: begin
        if (last_pat) begin
          next_state = S_WAIT;
          next_idx   = '0;
        end else begin
          next_idx = idx + SI_W'(1);
        end
      end
      S_WAIT: begin
        if (valid || wait_expired) next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the matcher sees a strobe
  // the cycle after the decision that produces it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      str_fresh <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      chardata  <= 8'h00;
      res_match <= 1'b0;
      res_index <= 5'd0;
      res_err   <= 1'b0;
`ifdef SME_HOST_FEEDER_TIMEOUT_EN
      res_timeout <= 1'b0;
`endif
    end else begin
      state <= next_state;
      idx   <= next_idx;
      if (state == S_DONE) str_fresh <= 1'b1;
      else if (str_wr)     str_fresh <= 1'b0;
      busy      <= (next_state == S_SEND_STR) || (next_state == S_SEND_PAT) ||
                   (next_state == S_WAIT);
      done      <= (next_state == S_DONE);
      isstring  <= (next_state == S_SEND_STR);
      ispattern <= (next_state == S_SEND_PAT);
      if (next_state == S_SEND_STR)      chardata <= str_rd;
      else if (next_state == S_SEND_PAT) chardata <= pat_rd;
      else                               chardata <= 8'h00;
      if (next_state == S_DONE) begin
        res_err   <= (state == S_IDLE);
        res_match <= got_result && match;
        res_index <= got_result ? match_index : 5'd0;
`ifdef SME_HOST_FEEDER_TIMEOUT_EN
        res_timeout <= (state == S_WAIT) && !valid;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sme_host_feeder.sv
// Self-checking bench for sme_host_feeder: a queue-based model of both buffers
// predicts every cycle of the matcher stream and the result registers.
module tb_sme_host_feeder;
  import sme_pkg::*;

`ifdef SME_HOST_FEEDER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 16;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en, wr_sel, start, reuse_str, valid, match;
  logic [7:0] wr_data;
  logic [4:0] match_index;
  logic       busy, done, res_match, res_err, res_timeout, isstring, ispattern;
  logic [4:0] res_index;
  logic [7:0] chardata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_str[$];
  logic [7:0] m_pat[$];
  bit         m_fresh;
  logic [7:0] m_res;  // {err, timeout, match, index[4:0]} as held since last DONE

  always #5 clk = ~clk;

  sme_host_feeder #(
    .STR_MAX(32),
    .PAT_MAX(8)
`ifdef SME_HOST_FEEDER_TIMEOUT_EN
    , .TIMEOUT(TB_TIMEOUT)
`endif
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .start(start), .reuse_str(reuse_str), .busy(busy), .done(done),
    .res_match(res_match), .res_index(res_index), .res_err(res_err),
    .res_timeout(res_timeout), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rand_byte();
    logic [7:0] meta [4];
    meta[0] = META_CARET; meta[1] = META_DOLLAR; meta[2] = META_DOT; meta[3] = META_STAR;
    if ($urandom_range(0, 3) == 0) return meta[$urandom_range(0, 3)];
    return 8'(8'h61 + $urandom_range(0, 25));
  endfunction

  task automatic model_reset();
    m_str.delete();
    m_pat.delete();
    m_fresh = 1'b0;
    m_res   = '0;
  endtask

  task automatic wr_byte(input buf_sel_e sel, input logic [7:0] d);
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b0;
    wr_en = 1'b1; wr_sel = sel; wr_data = d;
    if (sel == SEL_STR) begin
      if (m_fresh) begin
        m_str.delete();
        m_fresh = 1'b0;
      end
      if (m_str.size() < 32) m_str.push_back(d);
    end else if (m_pat.size() < 8) begin
      m_pat.push_back(d);
    end
  endtask

  task automatic load(input buf_sel_e sel, input string s);
    for (int i = 0; i < s.len(); i++) wr_byte(sel, s[i]);
  endtask

  // Launches one job and checks every cycle up to and including DONE.
  task automatic run_job(input string name, input bit reuse, input bit noise, input bit collide,
                         input int vdelay, input bit vmatch, input logic [4:0] vidx,
                         output int n_str_obs);
    logic [7:0] sq[$];
    logic [7:0] pq[$];
    bit         rej, timed_out;
    int         n, m, wait_entry, valid_cycle, done_cycle;
    logic       exp_busy, exp_done, exp_is, exp_ip;
    logic [7:0] exp_cd, new_res, exp_res;

    rej = (m_pat.size() == 0) || (m_str.size() == 0 && !reuse);
    if (!reuse) sq = m_str;
    pq = m_pat;
    n  = rej ? 0 : sq.size();
    m  = rej ? 0 : pq.size();
    wait_entry = n + m + 1;
    timed_out  = 1'b0;
`ifdef SME_HOST_FEEDER_TIMEOUT_EN
    timed_out = !rej && (vdelay >= TB_TIMEOUT);
`endif
    if (rej) begin
      valid_cycle = -1; done_cycle = 1;
    end else if (timed_out) begin
`ifdef SME_HOST_FEEDER_TIMEOUT_EN
      valid_cycle = -1; done_cycle = wait_entry + TB_TIMEOUT;
`endif
    end else begin
      valid_cycle = wait_entry + vdelay; done_cycle = valid_cycle + 1;
    end
    new_res = {rej, timed_out, (!rej && !timed_out) ? {vmatch, vidx} : 6'd0};
    n_str_obs = 0;

    @(posedge clk); #1;
    start = 1'b1; reuse_str = reuse; valid = 1'b0;
    wr_en = collide; wr_sel = SEL_STR; wr_data = 8'hAA;
    for (int c = 1; c <= done_cycle; c++) begin
      @(posedge clk); #1;
      start       = noise && (c == 2) && (c < done_cycle);
      reuse_str   = 1'b0;
      wr_en       = noise && (c == 3) && (c < done_cycle);
      wr_sel      = 1'($urandom_range(0, 1));
      wr_data     = 8'($urandom);
      valid       = (c == valid_cycle) || (noise && (c == 1) && (c < wait_entry));
      match       = (c == valid_cycle) ? vmatch : 1'($urandom);
      match_index = (c == valid_cycle) ? vidx : 5'($urandom);
      @(negedge clk);
      exp_is = (c <= n);
      exp_ip = (c > n) && (c <= n + m);
      exp_cd = 8'h00;
      if (exp_is) exp_cd = sq[c-1];
      if (exp_ip) exp_cd = pq[c-n-1];
      exp_busy = !rej && (c < done_cycle);
      exp_done = (c == done_cycle);
      if (isstring) n_str_obs++;
      checks++;
      if ({busy, done, isstring, ispattern, chardata} !== {exp_busy, exp_done, exp_is, exp_ip, exp_cd}) begin
        failures++;
        $display("FAIL %s cycle %0d stream: busy/done/isstr/ispat/char got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h",
                 name, c, busy, done, isstring, ispattern, chardata,
                 exp_busy, exp_done, exp_is, exp_ip, exp_cd);
      end
      exp_res = (c >= done_cycle) ? new_res : m_res;
      checks++;
      if ({res_err, res_timeout, res_match, res_index} !== exp_res) begin
        failures++;
        $display("FAIL %s cycle %0d results: err/to/match/idx got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 name, c, res_err, res_timeout, res_match, res_index,
                 exp_res[7], exp_res[6], exp_res[5], exp_res[4:0]);
      end
    end
    start = 1'b0; wr_en = 1'b0; valid = 1'b0;
    m_res = new_res;
    m_pat.delete();
    m_fresh = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, res_match, res_index, res_err, res_timeout, chardata, isstring, ispattern} !== '0) begin
      failures++;
      $display("FAIL reset outputs: got busy=%b done=%b match=%b idx=%0d err=%b to=%b char=%h is=%b ip=%b want all 0",
               busy, done, res_match, res_index, res_err, res_timeout, chardata, isstring, ispattern);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_hello();
    int n;
    load(SEL_STR, "hello world");
    load(SEL_PAT, "wor");
    run_job("hello", 1'b0, 1'b0, 1'b0, 2, 1'b1, 5'd6, n);
    checks++;
    if (n !== 11) begin
      failures++;
      $display("FAIL hello isstring count: got %0d want 11", n);
    end
  endtask

  task automatic test_reuse();
    int n;
    load(SEL_PAT, "xyz");
    run_job("reuse", 1'b1, 1'b0, 1'b0, 1, 1'b0, 5'd0, n);
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL reuse isstring count: got %0d want 0", n);
    end
  endtask

  task automatic test_empty_pat();
    int n;
    run_job("empty_pat", 1'b0, 1'b0, 1'b0, 0, 1'b1, 5'd3, n);
  endtask

  task automatic test_back_to_back();
    int n;
    load(SEL_STR, "abc");
    load(SEL_PAT, "bc");
    run_job("b2b_first", 1'b0, 1'b0, 1'b1, 0, 1'b1, 5'd1, n);
    run_job("b2b_second", 1'b0, 1'b0, 1'b0, 0, 1'b0, 5'd0, n);
  endtask

  task automatic test_overflow();
    int n;
    for (int i = 0; i < 34; i++) wr_byte(SEL_STR, rand_byte());
    for (int i = 0; i < 10; i++) wr_byte(SEL_PAT, rand_byte());
    run_job("overflow", 1'b0, 1'b0, 1'b0, 1, 1'b1, 5'd31, n);
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL overflow isstring count: got %0d want 32", n);
    end
  endtask

  task automatic test_wait();
    int n;
    load(SEL_STR, "ab");
    load(SEL_PAT, "$");
    run_job("long_wait", 1'b0, 1'b0, 1'b0, 40, 1'b1, 5'd1, n);
  endtask

`ifdef SME_HOST_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    load(SEL_PAT, "q.");
    run_job("valid_last_cycle", 1'b1, 1'b0, 1'b0, TB_TIMEOUT - 1, 1'b1, 5'd9, n);
    load(SEL_PAT, "z");
    run_job("timeout", 1'b1, 1'b0, 1'b0, 1000, 1'b1, 5'd9, n);
  endtask
`endif

  task automatic test_random();
    int n, sl, pl;
    for (int j = 0; j < 12; j++) begin
      sl = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 34);
      pl = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 9);
      for (int i = 0; i < sl; i++) wr_byte(SEL_STR, rand_byte());
      for (int i = 0; i < pl; i++) wr_byte(SEL_PAT, rand_byte());
      run_job($sformatf("rand%0d", j), ($urandom_range(0, 2) == 0), 1'b1,
              1'($urandom_range(0, 1)), $urandom_range(0, 5),
              1'($urandom_range(0, 1)), 5'($urandom), n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 8; i++) wr_byte(SEL_STR, rand_byte());
    wr_byte(SEL_PAT, rand_byte());
    wr_byte(SEL_PAT, rand_byte());
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (isstring !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid pre-reset isstring: got %b want 1", isstring);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, isstring, ispattern, chardata} !== '0) begin
      failures++;
      $display("FAIL reset_mid immediate drop: busy/done/is/ip/char got %b/%b/%b/%b/%h want 0",
               busy, done, isstring, ispattern, chardata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, isstring, ispattern} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_mid quiet cycle %0d: busy/done/is/ip got %b/%b/%b/%b want 0",
                 i, busy, done, isstring, ispattern);
      end
    end
    load(SEL_STR, "after.reset");
    load(SEL_PAT, "^a*");
    run_job("post_reset", 1'b0, 1'b0, 1'b0, 3, 1'b1, 5'd0, n);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_sel = 1'b0; wr_data = 8'h00;
    start = 1'b0; reuse_str = 1'b0;
    valid = 1'b0; match = 1'b0; match_index = 5'd0;
    model_reset();
    test_reset();
    test_hello();
    test_reuse();
    test_empty_pat();
    test_back_to_back();
    test_overflow();
    test_wait();
`ifdef SME_HOST_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
